// File: rtl/pc_sequencer.sv
// Fetch-stage controller: drives PC register load, instruction-memory handshake,
// hazard freeze, and prioritised redirect (exception, eret, branch, jump) with one pending slot.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_ena,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic        flush_if,
    output logic [31:0] epc_out
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Redirect classes are encoded so that a larger value means higher priority.
    localparam logic [1:0] CLS_JMP  = 2'd0;
    localparam logic [1:0] CLS_BR   = 2'd1;
    localparam logic [1:0] CLS_ERET = 2'd2;
    localparam logic [1:0] CLS_EXC  = 2'd3;

    state_t      state_r;
    state_t      state_next_s;
    logic        pend_valid_r;
    logic [31:0] pend_target_r;
    logic [1:0]  pend_class_r;
    logic        pend_valid_next_s;
    logic [31:0] pend_target_next_s;
    logic [1:0]  pend_class_next_s;
    logic [31:0] epc_r;
    logic [31:0] epc_next_s;

    logic        adv_s;
    logic        in_valid_s;
    logic [1:0]  in_class_s;
    logic [31:0] in_target_s;
    logic        sel_valid_s;
    logic [31:0] sel_target_s;

    // Decide whether a new redirect of class nc may replace the pending entry.
    // exc/eret are precise-state events and replace anything except that eret
    // never displaces a pending exc; control-flow redirects never displace them.
    function automatic logic may_overwrite(
        input logic       pv,
        input logic [1:0] pc,
        input logic [1:0] nc
    );
        logic r;
        if (!pv) begin
            r = 1'b1;
        end else if (nc == CLS_EXC) begin
            r = 1'b1;
        end else if (nc == CLS_ERET) begin
            r = (pc != CLS_EXC);
        end else if ((pc == CLS_EXC) || (pc == CLS_ERET)) begin
            r = 1'b0;
        end else begin
            r = (nc >= pc);
        end
        return r;
    endfunction

    // Highest-priority redirect presented on the inputs this cycle.
    always_comb begin
        in_valid_s  = 1'b0;
        in_class_s  = CLS_JMP;
        in_target_s = jmp_target;
        if (exc_valid) begin
            in_valid_s  = 1'b1;
            in_class_s  = CLS_EXC;
            in_target_s = EXC_VECTOR;
        end else if (eret) begin
            in_valid_s  = 1'b1;
            in_class_s  = CLS_ERET;
            in_target_s = epc_r;
        end else if (br_taken) begin
            in_valid_s  = 1'b1;
            in_class_s  = CLS_BR;
            in_target_s = br_target;
        end else if (jmp_valid) begin
            in_valid_s  = 1'b1;
            in_class_s  = CLS_JMP;
            in_target_s = jmp_target;
        end else begin
            in_valid_s  = 1'b0;
        end
    end

    // Merge pending and same-cycle redirects; on a class tie the newer input wins.
    always_comb begin
        sel_valid_s  = 1'b0;
        sel_target_s = pc_cur;
        if (pend_valid_r && (!in_valid_s || (pend_class_r > in_class_s))) begin
            sel_valid_s  = 1'b1;
            sel_target_s = pend_target_r;
        end else if (in_valid_s) begin
            sel_valid_s  = 1'b1;
            sel_target_s = in_target_s;
        end else begin
            sel_valid_s  = 1'b0;
        end
    end

    // FSM next-state, request and advance decode.
    always_comb begin
        state_next_s = state_r;
        adv_s        = 1'b0;
        imem_req     = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (!stall) begin
                        adv_s = 1'b1;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    adv_s        = 1'b1;
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
    end

    // PC register controls; pc_cur+4 wraps naturally at 32 bits.
    always_comb begin
        pc_ena   = adv_s;
        pc_next  = pc_cur;
        flush_if = 1'b0;
        if (adv_s) begin
            if (sel_valid_s) begin
                pc_next  = sel_target_s;
                flush_if = 1'b1;
            end else begin
                pc_next  = pc_cur + 32'd4;
                flush_if = 1'b0;
            end
        end else begin
            pc_next  = pc_cur;
            flush_if = 1'b0;
        end
    end

    // Pending slot update: cleared by an advance, otherwise loaded under the overwrite rules.
    always_comb begin
        pend_valid_next_s  = pend_valid_r;
        pend_target_next_s = pend_target_r;
        pend_class_next_s  = pend_class_r;
        if (adv_s) begin
            pend_valid_next_s = 1'b0;
        end else if (in_valid_s && may_overwrite(pend_valid_r, pend_class_r, in_class_s)) begin
            pend_valid_next_s  = 1'b1;
            pend_target_next_s = in_target_s;
            pend_class_next_s  = in_class_s;
        end else begin
            pend_valid_next_s = pend_valid_r;
        end
    end

    // An exception is always either applied or latched, so EPC captures it unconditionally.
    always_comb begin
        if (exc_valid) begin
            epc_next_s = exc_pc;
        end else begin
            epc_next_s = epc_r;
        end
    end

    assign epc_out = epc_r;

    // State, pending slot and EPC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_BOOT;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
            pend_class_r  <= CLS_JMP;
            epc_r         <= RESET_PC;
        end else begin
            state_r       <= state_next_s;
            pend_valid_r  <= pend_valid_next_s;
            pend_target_r <= pend_target_next_s;
            pend_class_r  <= pend_class_next_s;
            epc_r         <= epc_next_s;
        end
    end

endmodule
